// File: rtl/bellek_yanitlayici_pkg.sv
// Shared constants (sabitler) and types for the memory responder.
// The block's optional address check is enabled with BELLEK_ADRES_KONTROL_EN.
`ifndef VERI_BIT
`define VERI_BIT 32
`endif
`ifndef ADRES_BIT
`define ADRES_BIT 32
`endif
`ifndef BELLEK_BASLANGIC
`define BELLEK_BASLANGIC 32'h8000_0000
`endif
`ifndef BELLEK_BOYUT
`define BELLEK_BOYUT 32'h0000_4000
`endif
`ifndef HIGH
`define HIGH 1'b1
`endif
`ifndef LOW
`define LOW 1'b0
`endif

package bellek_yanitlayici_pkg;

  typedef enum logic {
    ISTEK_OKU = 1'b0,
    ISTEK_YAZ = 1'b1
  } istek_tur_e;

  localparam logic [31:0] HATA_DESENI = 32'hDEAD_BEEF;

  function automatic int unsigned bayt_kaydirma(input int unsigned veri_bit);
    return $clog2(veri_bit / 8);
  endfunction

endpackage

// File: rtl/bellek_yanitlayici_fifo.sv
// Response FIFO (module yanit_fifo): register array with a combinational head.
module yanit_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push_i) wr_d = wr_q + 1'b1;
    if (pop_i)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q[PW-2:0]] <= din_i;
  end

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[PW-1] != rd_q[PW-1]) && (wr_q[PW-2:0] == rd_q[PW-2:0]);
  assign dout_o  = mem_q[rd_q[PW-2:0]];

endmodule

// File: rtl/bellek_yanitlayici.sv
// Pipelined memory responder: credit-limited request accept, delay line, response FIFO.
// Define BELLEK_ADRES_KONTROL_EN to add range checking and the sticky hata_o port.
module bellek_yanitlayici
  import bellek_yanitlayici_pkg::*;
#(
  parameter int unsigned          VERI_BIT      = `VERI_BIT,
  parameter int unsigned          ADRES_BIT     = `ADRES_BIT,
  parameter logic [ADRES_BIT-1:0] BASLANGIC     = `BELLEK_BASLANGIC,
  parameter int unsigned          DERINLIK      = 4096,
  parameter int unsigned          GECIKME       = 1,
  parameter int unsigned          FIFO_DERINLIK = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [ADRES_BIT-1:0] mem_istek_adres_i,
  input  logic [VERI_BIT-1:0]  mem_istek_veri_i,
  input  logic                 mem_istek_yaz_i,
  input  logic                 mem_istek_gecerli_i,
  output logic                 mem_istek_hazir_o,
  output logic [VERI_BIT-1:0]  mem_veri_o,
  output logic                 mem_veri_gecerli_o,
  input  logic                 mem_veri_hazir_i
`ifdef BELLEK_ADRES_KONTROL_EN
  ,
  output logic                 hata_o
`endif
);

  localparam int unsigned OFS_BIT = bayt_kaydirma(VERI_BIT);
  localparam int unsigned AW      = $clog2(DERINLIK);
  localparam int unsigned KW      = $clog2(FIFO_DERINLIK + 1);

  logic                 kabul;
  logic                 cikis;
  logic                 adres_hata;
  istek_tur_e           tur;
  logic [ADRES_BIT-1:0] ofs;
  logic [AW-1:0]        idx;
  logic [VERI_BIT-1:0]  yanit;
  logic [VERI_BIT-1:0]  mem_q [DERINLIK];
  logic [KW-1:0]        kredi_q, kredi_d;
  logic                 push;
  logic [VERI_BIT-1:0]  push_veri;
  logic                 fifo_bos;
  logic                 fifo_dolu;
  logic [VERI_BIT-1:0]  fifo_bas;

  assign mem_istek_hazir_o  = !rst_i && (kredi_q < KW'(FIFO_DERINLIK));
  assign kabul              = mem_istek_gecerli_i && mem_istek_hazir_o;
  assign mem_veri_gecerli_o = !rst_i && !fifo_bos;
  assign mem_veri_o         = mem_veri_gecerli_o ? fifo_bas : '0;
  assign cikis              = mem_veri_gecerli_o && mem_veri_hazir_i;

  assign tur = istek_tur_e'(mem_istek_yaz_i);
  assign ofs = mem_istek_adres_i - BASLANGIC;
  assign idx = AW'(ofs >> OFS_BIT);

`ifdef BELLEK_ADRES_KONTROL_EN
  logic hata_q;

  assign adres_hata = (mem_istek_adres_i < BASLANGIC) ||
                      ((ofs >> OFS_BIT) >= ADRES_BIT'(DERINLIK));

  always_ff @(posedge clk_i) begin
    if (rst_i)                    hata_q <= `LOW;
    else if (kabul && adres_hata) hata_q <= `HIGH;
  end

  assign hata_o = hata_q;
`else
  assign adres_hata = `LOW;
`endif

  always_comb begin
    yanit = mem_istek_veri_i;
    if (tur == ISTEK_OKU) yanit = adres_hata ? {(VERI_BIT / 32){HATA_DESENI}} : mem_q[idx];
  end

  // Storage deliberately has no reset.
  always_ff @(posedge clk_i) begin
    if (kabul && (tur == ISTEK_YAZ) && !adres_hata) mem_q[idx] <= mem_istek_veri_i;
  end

  always_comb begin
    kredi_d = kredi_q;
    if (kabul && !cikis)      kredi_d = kredi_q + 1'b1;
    else if (!kabul && cikis) kredi_d = kredi_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) kredi_q <= '0;
    else       kredi_q <= kredi_d;
  end

  // The FIFO write edge is the last delay stage, so GECIKME-1 registers precede it.
  if (GECIKME == 1) begin : g_dogrudan
    assign push      = kabul;
    assign push_veri = yanit;
  end else begin : g_hat
    logic                vld_q  [GECIKME-1];
    logic [VERI_BIT-1:0] veri_q [GECIKME-1];

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int unsigned i = 0; i < GECIKME - 1; i++) vld_q[i] <= 1'b0;
      end else begin
        vld_q[0] <= kabul;
        for (int unsigned i = 1; i < GECIKME - 1; i++) vld_q[i] <= vld_q[i-1];
      end
    end

    always_ff @(posedge clk_i) begin
      veri_q[0] <= yanit;
      for (int unsigned i = 1; i < GECIKME - 1; i++) veri_q[i] <= veri_q[i-1];
    end

    assign push      = vld_q[GECIKME-2];
    assign push_veri = veri_q[GECIKME-2];
  end

  yanit_fifo #(
    .WIDTH (VERI_BIT),
    .DEPTH (FIFO_DERINLIK)
  ) u_yanit_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .din_i   (push_veri),
    .pop_i   (cikis),
    .dout_o  (fifo_bas),
    .full_o  (fifo_dolu),
    .empty_o (fifo_bos)
  );

  a_fifo_tasma: assert property (@(posedge clk_i) disable iff (rst_i) !(push && fifo_dolu && !cikis));

endmodule

// File: tb/tb_bellek_yanitlayici.sv
// Bench for bellek_yanitlayici: vector table, latency/back-pressure/reset sequences, stride sweep.
module tb_bellek_yanitlayici;

  localparam int unsigned W   = 32;
  localparam int unsigned GEC = 3;
  localparam int unsigned FD  = 4;
  localparam int unsigned DER = 256;
  localparam logic [31:0] B   = `BELLEK_BASLANGIC;

  logic          clk;
  logic          rst_i;
  logic [31:0]   adres_i;
  logic [W-1:0]  veri_i;
  logic          yaz_i;
  logic          gecerli_i;
  logic          hazir_o;
  logic [W-1:0]  veri_o;
  logic          gecerli_o;
  logic          hazir_i;
`ifdef BELLEK_ADRES_KONTROL_EN
  logic          hata_o;
`endif

  bellek_yanitlayici #(
    .VERI_BIT      (W),
    .ADRES_BIT     (32),
    .BASLANGIC     (B),
    .DERINLIK      (DER),
    .GECIKME       (GEC),
    .FIFO_DERINLIK (FD)
  ) dut (
    .clk_i               (clk),
    .rst_i               (rst_i),
    .mem_istek_adres_i   (adres_i),
    .mem_istek_veri_i    (veri_i),
    .mem_istek_yaz_i     (yaz_i),
    .mem_istek_gecerli_i (gecerli_i),
    .mem_istek_hazir_o   (hazir_o),
    .mem_veri_o          (veri_o),
    .mem_veri_gecerli_o  (gecerli_o),
    .mem_veri_hazir_i    (hazir_i)
`ifdef BELLEK_ADRES_KONTROL_EN
    ,
    .hata_o              (hata_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        yaz;
    logic [31:0] adres;
    logic [31:0] veri;
    logic [31:0] bek;
  } vektor_t;

  vektor_t     tablo [10];
  int          n_kars = 0;
  int          n_hata = 0;
  int          cyc = 0;
  int          el_say = 0;
  int          son_kabul = 0;
  logic [31:0] exp_q [$];
  int          acc_q [$];
  bit          tam_gecikme = 0;
  bit          rastgele = 0;
  logic        onceki_g = 0;
  logic        onceki_el = 0;
  logic [31:0] onceki_v = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic kontrol(input string ad, input logic [31:0] gercek, input logic [31:0] bek);
    n_kars++;
    if (gercek !== bek) begin
      n_hata++;
      $display("FAIL %s: got %h want %h (cycle %0d)", ad, gercek, bek, cyc);
    end
  endtask

  // Response monitor: stability while stalled, first-beat latency, in-order data.
  always @(negedge clk) begin
    if (rst_i) begin
      onceki_g  = 1'b0;
      onceki_el = 1'b0;
    end else begin
      if (onceki_g && !onceki_el) begin
        kontrol("kararlilik_gecerli", {31'd0, gecerli_o}, 32'd1);
        kontrol("kararlilik_veri", veri_o, onceki_v);
      end
      if (gecerli_o) begin
        if (tam_gecikme && (!onceki_g || onceki_el) && acc_q.size() > 0)
          kontrol("gecikme", cyc - acc_q[0], GEC);
        if (hazir_i) begin
          el_say++;
          if (exp_q.size() == 0) begin
            kontrol("bayat_yanit", veri_o, 32'hxxxx_xxxx);
          end else begin
            kontrol("yanit_veri", veri_o, exp_q.pop_front());
            void'(acc_q.pop_front());
          end
        end
      end
      onceki_g  = gecerli_o;
      onceki_el = gecerli_o && hazir_i;
      onceki_v  = veri_o;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rastgele) hazir_i = 1'($urandom_range(0, 1));
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic istek(input logic yaz, input logic [31:0] adres, input logic [31:0] veri,
                       input logic [31:0] bek);
    int unsigned bekle;
    bekle     = 0;
    gecerli_i = 1'b1;
    yaz_i     = yaz;
    adres_i   = adres;
    veri_i    = veri;
    @(negedge clk);
    while (!hazir_o && bekle < 500) begin
      bekle++;
      @(negedge clk);
    end
    if (!hazir_o) begin
      kontrol("istek_zaman_asimi", {31'd0, hazir_o}, 32'd1);
    end else begin
      exp_q.push_back(bek);
      acc_q.push_back(cyc);
      son_kabul = cyc;
    end
    @(posedge clk);
    #1;
    gecerli_i = 1'b0;
  endtask

  task automatic bosalt();
    for (int k = 0; k < 2000 && exp_q.size() != 0; k++) @(negedge clk);
    kontrol("bosalt_kalan", exp_q.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          sayac;
    int          el0;
    int          ilk;
    logic [7:0]  bayt;
    logic [31:0] d;
    logic [31:0] idx;

    rst_i = 1'b1; gecerli_i = 1'b0; yaz_i = 1'b0; adres_i = '0; veri_i = '0; hazir_i = 1'b1;

    tablo[0] = '{1'b1, B + 32'h010, 32'h1122_3344, 32'h1122_3344};
    tablo[1] = '{1'b0, B + 32'h010, 32'h0,         32'h1122_3344};
    tablo[2] = '{1'b1, B + 32'h000, 32'hA5A5_0001, 32'hA5A5_0001};
    tablo[3] = '{1'b0, B + 32'h013, 32'h0,         32'h1122_3344};
    tablo[4] = '{1'b1, B + 32'h3FC, 32'hCAFE_F00D, 32'hCAFE_F00D};
    tablo[5] = '{1'b0, B + 32'h3FC, 32'h0,         32'hCAFE_F00D};
    tablo[7] = '{1'b1, B + 32'h402, 32'h0BAD_0BAD, 32'h0BAD_0BAD};
`ifdef BELLEK_ADRES_KONTROL_EN
    tablo[6] = '{1'b0, B + 32'h400, 32'h0,         32'hDEAD_BEEF};
    tablo[8] = '{1'b0, B + 32'h000, 32'h0,         32'hA5A5_0001};
    tablo[9] = '{1'b0, B - 32'h004, 32'h0,         32'hDEAD_BEEF};
`else
    tablo[6] = '{1'b0, B + 32'h400, 32'h0,         32'hA5A5_0001};
    tablo[8] = '{1'b0, B + 32'h000, 32'h0,         32'h0BAD_0BAD};
    tablo[9] = '{1'b0, B - 32'h004, 32'h0,         32'hCAFE_F00D};
`endif

    repeat (2) @(posedge clk);
    @(negedge clk);
    kontrol("reset_hazir_o", {31'd0, hazir_o}, 32'd0);
    kontrol("reset_gecerli_o", {31'd0, gecerli_o}, 32'd0);
    kontrol("reset_veri_o", veri_o, 32'd0);
    @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    kontrol("reset_sonrasi_hazir", {31'd0, hazir_o}, 32'd1);
    @(posedge clk);
    #1;

    tam_gecikme = 1'b1;
    for (int i = 0; i < 10; i++) istek(tablo[i].yaz, tablo[i].adres, tablo[i].veri, tablo[i].bek);
    bosalt();
`ifdef BELLEK_ADRES_KONTROL_EN
    kontrol("hata_o", {31'd0, hata_o}, 32'd1);
`endif

    for (int i = 0; i < 100; i++) istek(1'b1, B + 32'(4 * i), 32'(i), 32'(i));
    for (int i = 0; i < 100; i++) begin
      istek(1'b0, B + 32'(4 * i), 32'h0, 32'(i));
      if (i == 0) ilk = son_kabul;
    end
    kontrol("arka_arkaya_kabul", son_kabul - ilk, 32'd99);
    bosalt();
    tam_gecikme = 1'b0;

    hazir_i = 1'b0; sayac = 0; gecerli_i = 1'b1; yaz_i = 1'b0;
    for (int k = 0; k < 12; k++) begin
      adres_i = B + 32'(4 * (10 + sayac));
      @(negedge clk);
      if (hazir_o) begin
        exp_q.push_back(32'(10 + sayac));
        acc_q.push_back(cyc);
        sayac++;
      end
      @(posedge clk);
      #1;
    end
    gecerli_i = 1'b0;
    kontrol("kredi_kabul_sayisi", sayac, FD);
    @(negedge clk);
    kontrol("kredi_dolu_hazir_o", {31'd0, hazir_o}, 32'd0);
    @(posedge clk);
    #1;
    el0 = el_say;
    hazir_i = 1'b1;
    bosalt();
    kontrol("kredi_yanit_sayisi", el_say - el0, FD);
    @(negedge clk);
    kontrol("kredi_geri_hazir_o", {31'd0, hazir_o}, 32'd1);
    @(posedge clk);
    #1;

    hazir_i = 1'b0;
    for (int i = 20; i < 23; i++) istek(1'b0, B + 32'(4 * i), 32'h0, 32'(i));
    repeat (4) @(posedge clk);
    #1 rst_i = 1'b1;
    exp_q.delete();
    acc_q.delete();
    @(negedge clk);
    kontrol("orta_reset_gecerli", {31'd0, gecerli_o}, 32'd0);
    kontrol("orta_reset_hazir", {31'd0, hazir_o}, 32'd0);
    kontrol("orta_reset_veri", veri_o, 32'd0);
    @(posedge clk);
    #1 rst_i = 1'b0;
    hazir_i = 1'b1;
    @(negedge clk);
    kontrol("orta_reset_sonra_gecerli", {31'd0, gecerli_o}, 32'd0);
    repeat (10) @(posedge clk);
    #1;
    for (int i = 20; i < 23; i++) istek(1'b0, B + 32'(4 * i), 32'h0, 32'(i));
    bosalt();

    rastgele = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      idx  = 32'((i * 37) % DER);
      bayt = i[7:0] + 8'd1;
      d    = {4{bayt}};
      istek(1'b1, B + (idx << 2), d, d);
      istek(1'b0, B + (idx << 2), 32'h0, d);
    end
    bosalt();
    rastgele = 1'b0;
    hazir_i  = 1'b1;
    repeat (5) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_kars, n_hata);
    $finish;
  end

endmodule
